// File: rtl/demux_reg_1ton_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_reg_1ton_if
// Description : Bundle of the flit input handshake and the per-port output
//               handshakes of demux_reg_1ton.
//               master : flit producer and output consumers (drives din,
//                        din_valid, sel, dout_ready)
//               slave  : the demultiplexer itself
//               Ports carried:
//                 din        [WIDTH]          input flit
//                 din_valid  [1]              input flit valid
//                 sel        [SEL_W]          destination port index
//                 din_ready  [1]              demux can accept din
//                 dout       [NUM_OUT*WIDTH]  port k data at [k*WIDTH +: WIDTH]
//                 dout_valid [NUM_OUT]        per-port head flit valid
//                 dout_ready [NUM_OUT]        per-port consumer ready
//                 sel_err    [1]              illegal-sel drop pulse
//                 drop_cnt   [16]             only with DEMUX_REG_DROP_CNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_reg_1ton_if #(
  parameter int WIDTH   = 1,
  parameter int NUM_OUT = 5,
  parameter int SEL_W   = 3
);
  logic [WIDTH-1:0]         din;
  logic                     din_valid;
  logic [SEL_W-1:0]         sel;
  logic                     din_ready;
  logic [NUM_OUT*WIDTH-1:0] dout;
  logic [NUM_OUT-1:0]       dout_valid;
  logic [NUM_OUT-1:0]       dout_ready;
  logic                     sel_err;
`ifdef DEMUX_REG_DROP_CNT_EN
  logic [15:0]              drop_cnt;
`endif

  modport master (
    output din, din_valid, sel, dout_ready,
`ifdef DEMUX_REG_DROP_CNT_EN
    input  drop_cnt,
`endif
    input  din_ready, dout, dout_valid, sel_err
  );

  modport slave (
    input  din, din_valid, sel, dout_ready,
`ifdef DEMUX_REG_DROP_CNT_EN
    output drop_cnt,
`endif
    output din_ready, dout, dout_valid, sel_err
  );
endinterface
`default_nettype wire

// File: rtl/demux_reg_1ton.sv
`default_nettype none
// ============================================================================
// Module      : demux_reg_1ton
// Description : Registered 1-to-NUM_OUT flit demultiplexer with valid/ready
//               handshaking. Every output port owns a 2-entry skid FIFO, so a
//               stalled port never blocks flits headed for other ports.
//               Flits with sel >= NUM_OUT are accepted, dropped and flagged
//               with a one-cycle sel_err pulse.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-high reset
//               bus   - demux_reg_1ton_if.slave (din/din_valid/sel/din_ready,
//                       dout/dout_valid/dout_ready, sel_err, drop_cnt)
// Options     : DEMUX_REG_DROP_CNT_EN - adds the saturating 16-bit drop_cnt
//               output counting dropped illegal-sel flits.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_reg_1ton #(
  parameter int WIDTH   = 1,
  parameter int NUM_OUT = 5,
  parameter int SEL_W   = 3
) (
  input  wire logic          clk,
  input  wire logic          reset,
  demux_reg_1ton_if.slave    bus
);

  // Extra bit so NUM_OUT == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0] c_num_out = (SEL_W+1)'(NUM_OUT);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fifo_state_e;

  logic               w_sel_legal;
  logic               w_sel_full;
  logic               w_din_ready;
  logic               w_accept;
  logic               w_drop;
  logic [NUM_OUT-1:0] w_full;
  logic [NUM_OUT-1:0] w_push;
  logic               r_sel_err;

  // --------------------------------------------------------------------------
  // Input side: ready is derived from registered FIFO occupancy and sel only,
  // never from dout_ready, so no combinational path runs output -> input.
  // --------------------------------------------------------------------------
  assign w_sel_legal = ({1'b0, bus.sel} < c_num_out);

  always_comb begin
    w_sel_full = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        w_sel_full = w_full[k];
      end
    end
  end

  assign w_din_ready = w_sel_legal ? ~w_sel_full : 1'b1;
  assign w_accept    = bus.din_valid & w_din_ready;
  assign w_drop      = w_accept & ~w_sel_legal;

  always_comb begin
    w_push = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      w_push[k] = w_accept & w_sel_legal & (bus.sel == SEL_W'(k));
    end
  end

  assign bus.din_ready = w_din_ready;

  // --------------------------------------------------------------------------
  // Per-port 2-entry FIFO: head register drives dout directly, tail holds the
  // second flit while the head is stalled.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_port
      fifo_state_e      r_state;
      fifo_state_e      w_state_nxt;
      logic [WIDTH-1:0] r_head;
      logic [WIDTH-1:0] r_tail;
      logic [WIDTH-1:0] w_head_nxt;
      logic [WIDTH-1:0] w_tail_nxt;
      logic             w_valid;
      logic             w_pop;

      assign w_valid   = (r_state != ST_EMPTY);
      assign w_pop     = w_valid & bus.dout_ready[k];
      assign w_full[k] = (r_state == ST_TWO);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_state <= ST_EMPTY;
          r_head  <= '0;
          r_tail  <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_head  <= w_head_nxt;
          r_tail  <= w_tail_nxt;
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
          ST_EMPTY: begin
            if (w_push[k]) begin
              w_state_nxt = ST_ONE;
              w_head_nxt  = bus.din;
            end
          end
          ST_ONE: begin
            if (w_push[k] && w_pop) begin
              // Head leaves and the new flit replaces it in the same edge.
              w_head_nxt = bus.din;
            end else if (w_push[k]) begin
              w_state_nxt = ST_TWO;
              w_tail_nxt  = bus.din;
            end else if (w_pop) begin
              w_state_nxt = ST_EMPTY;
            end
          end
          ST_TWO: begin
            // din_ready is low for this port, so only a pop can happen here.
            if (w_pop) begin
              w_state_nxt = ST_ONE;
              w_head_nxt  = r_tail;
            end
          end
          default: begin
            w_state_nxt = ST_EMPTY;
          end
        endcase
      end

      assign bus.dout[k*WIDTH +: WIDTH] = r_head;
      assign bus.dout_valid[k]          = w_valid;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Illegal-select reporting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_drop;
    end
  end

  assign bus.sel_err = r_sel_err;

`ifdef DEMUX_REG_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.drop_cnt = r_drop_cnt;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_reg_1ton.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_reg_1ton
// Description : Self-checking bench for demux_reg_1ton (WIDTH=8, NUM_OUT=5,
//               SEL_W=3). Directed vector table plus hand-written sequences
//               for backpressure, non-blocking ports and reset mid-stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_reg_1ton;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  demux_reg_1ton_if #(.WIDTH(8), .NUM_OUT(5), .SEL_W(3)) bus ();

  demux_reg_1ton #(.WIDTH(8), .NUM_OUT(5), .SEL_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       vld;
    logic [2:0] sel;
    logic [4:0] rdy;
    logic       e_rdy;   // din_ready before the edge
    logic [4:0] e_dv;    // dout_valid after the edge
    logic       e_err;   // sel_err after the edge
    int         e_port;  // port whose head is checked (-1: none)
    logic [7:0] e_data;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycle(input string nm, input logic [7:0] d, input logic v,
                       input logic [2:0] s, input logic [4:0] r, input logic e_rdy,
                       input logic [4:0] e_dv, input logic e_err, input int e_port,
                       input logic [7:0] e_data);
    @(negedge clk);
    bus.din        = d;
    bus.din_valid  = v;
    bus.sel        = s;
    bus.dout_ready = r;
    #1;
    chk({nm, " din_ready"}, 40'(bus.din_ready), 40'(e_rdy));
    @(posedge clk);
    #1;
    chk({nm, " dout_valid"}, 40'(bus.dout_valid), 40'(e_dv));
    chk({nm, " sel_err"}, 40'(bus.sel_err), 40'(e_err));
    if (e_port >= 0 && e_dv[e_port]) begin
      chk({nm, " dout"}, 40'(bus.dout[e_port*8 +: 8]), 40'(e_data));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.sel        = '0;
    bus.dout_ready = '0;

    //            din   vld  sel  rdy       e_rdy e_dv      e_err port data
    tv[0]  = '{8'hA5, 1'b1, 3'd3, 5'h1F,    1'b1, 5'b01000, 1'b0, 3, 8'hA5}; // single flit
    tv[1]  = '{8'h00, 1'b0, 3'd3, 5'h1F,    1'b1, 5'b00000, 1'b0, -1, 8'h00}; // consumed
    tv[2]  = '{8'h77, 1'b1, 3'd6, 5'h1F,    1'b1, 5'b00000, 1'b1, -1, 8'h00}; // illegal sel
    tv[3]  = '{8'h77, 1'b0, 3'd6, 5'h1F,    1'b1, 5'b00000, 1'b0, -1, 8'h00}; // pulse ends
    tv[4]  = '{8'h78, 1'b1, 3'd7, 5'h00,    1'b1, 5'b00000, 1'b1, -1, 8'h00}; // illegal sel 7
    tv[5]  = '{8'hAA, 1'b1, 3'd0, 5'h00,    1'b1, 5'b00001, 1'b0, 0, 8'hAA}; // port0 ONE
    tv[6]  = '{8'hBB, 1'b1, 3'd0, 5'h01,    1'b1, 5'b00001, 1'b0, 0, 8'hBB}; // push+pop in ONE
    tv[7]  = '{8'h00, 1'b0, 3'd0, 5'h00,    1'b1, 5'b00001, 1'b0, 0, 8'hBB}; // head stable
    tv[8]  = '{8'hCC, 1'b1, 3'd0, 5'h00,    1'b1, 5'b00001, 1'b0, 0, 8'hBB}; // -> TWO
    tv[9]  = '{8'hDD, 1'b1, 3'd0, 5'h00,    1'b0, 5'b00001, 1'b0, 0, 8'hBB}; // full, held
    tv[10] = '{8'hDD, 1'b1, 3'd0, 5'h01,    1'b0, 5'b00001, 1'b0, 0, 8'hCC}; // pop, tail->head
    tv[11] = '{8'hDD, 1'b1, 3'd0, 5'h01,    1'b1, 5'b00001, 1'b0, 0, 8'hDD}; // accepted now
    tv[12] = '{8'h00, 1'b0, 3'd0, 5'h01,    1'b1, 5'b00000, 1'b0, -1, 8'h00}; // drained

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset dout_valid", 40'(bus.dout_valid), 40'd0);
    chk("reset dout", bus.dout, 40'd0);
    chk("reset sel_err", 40'(bus.sel_err), 40'd0);

    for (int i = 0; i < 13; i++) begin
      cycle($sformatf("vec%0d", i), tv[i].din, tv[i].vld, tv[i].sel, tv[i].rdy,
            tv[i].e_rdy, tv[i].e_dv, tv[i].e_err, tv[i].e_port, tv[i].e_data);
    end

`ifdef DEMUX_REG_DROP_CNT_EN
    chk("drop_cnt after table", 40'(bus.drop_cnt), 40'd2);
`endif

    // Backpressure on port 0: third flit waits until the first pop frees space.
    cycle("bp 11",       8'h11, 1'b1, 3'd0, 5'h00, 1'b1, 5'b00001, 1'b0, 0, 8'h11);
    cycle("bp 22",       8'h22, 1'b1, 3'd0, 5'h00, 1'b1, 5'b00001, 1'b0, 0, 8'h11);
    cycle("bp 33 held",  8'h33, 1'b1, 3'd0, 5'h00, 1'b0, 5'b00001, 1'b0, 0, 8'h11);
    cycle("bp pop 11",   8'h33, 1'b1, 3'd0, 5'h01, 1'b0, 5'b00001, 1'b0, 0, 8'h22);
    cycle("bp pop 22",   8'h33, 1'b1, 3'd0, 5'h01, 1'b1, 5'b00001, 1'b0, 0, 8'h33);
    cycle("bp pop 33",   8'h00, 1'b0, 3'd0, 5'h01, 1'b1, 5'b00000, 1'b0, -1, 8'h00);

    // Port 1 full and stalled while port 4 streams at full rate.
    cycle("nb fill 91",  8'h91, 1'b1, 3'd1, 5'h00, 1'b1, 5'b00010, 1'b0, 1, 8'h91);
    cycle("nb fill 92",  8'h92, 1'b1, 3'd1, 5'h00, 1'b1, 5'b00010, 1'b0, 1, 8'h91);
    for (int i = 0; i < 16; i++) begin
      cycle($sformatf("nb stream %0d", i), 8'h40 + 8'(i), 1'b1, 3'd4, 5'b10000,
            1'b1, 5'b10010, 1'b0, 4, 8'h40 + 8'(i));
      chk("nb port1 hold", 40'(bus.dout[15:8]), 40'h91);
    end
    cycle("nb p1 full",  8'h93, 1'b1, 3'd1, 5'b10000, 1'b0, 5'b00010, 1'b0, 1, 8'h91);
    cycle("nb drain 91", 8'h00, 1'b0, 3'd1, 5'b00010, 1'b0, 5'b00010, 1'b0, 1, 8'h92);
    cycle("nb drain 92", 8'h00, 1'b0, 3'd1, 5'b00010, 1'b1, 5'b00000, 1'b0, -1, 8'h00);

`ifdef DEMUX_REG_DROP_CNT_EN
    cycle("dc one more", 8'h55, 1'b1, 3'd5, 5'h1F, 1'b1, 5'b00000, 1'b1, -1, 8'h00);
    chk("drop_cnt 3", 40'(bus.drop_cnt), 40'd3);
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      bus.din_valid = 1'b1;
      bus.sel       = 3'd6;
    end
    @(posedge clk);
    #1;
    chk("drop_cnt saturate", 40'(bus.drop_cnt), 40'hFFFF);
    chk("drop_cnt no fifo", 40'(bus.dout_valid), 40'd0);
`endif

    // Reset mid-stream with port 2 holding two flits.
    cycle("rm push 21",  8'h21, 1'b1, 3'd2, 5'h00, 1'b1, 5'b00100, 1'b0, 2, 8'h21);
    cycle("rm push 22",  8'h22, 1'b1, 3'd2, 5'h00, 1'b1, 5'b00100, 1'b0, 2, 8'h21);
    @(negedge clk);
    bus.din_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rm async dout_valid", 40'(bus.dout_valid), 40'd0);
    chk("rm async dout", bus.dout, 40'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.sel = 3'd2;
    #1;
    chk("rm din_ready", 40'(bus.din_ready), 40'd1);
`ifdef DEMUX_REG_DROP_CNT_EN
    chk("rm drop_cnt", 40'(bus.drop_cnt), 40'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("rm idle %0d", i), 8'h00, 1'b0, 3'd2, 5'h1F, 1'b1, 5'b00000,
            1'b0, -1, 8'h00);
    end
    cycle("rm fresh",    8'h5A, 1'b1, 3'd2, 5'h00, 1'b1, 5'b00100, 1'b0, 2, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
